// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-limited pipelined inst_sram requests feeding an in-order
// instruction FIFO in front of ID, with WB/ID redirects and exception entries.
module if_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] PC_INIT   = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  input  logic [31:0] pc_trans,
  input  logic        except_tlbr,
  input  logic        except_pif,
  input  logic        except_ppi,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        id_flush,
  input  logic [31:0] id_flush_target,
  output logic        if_valid,
  input  logic        id_allowin,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [3:0]  if_except
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int OW   = $clog2(MAX_OUTST + 1);
  localparam int TW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW   = CNTW + OW + 1;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTST - 1)) return '0;
    return p + TW'(1);
  endfunction

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic            req_discard_q, req_discard_d;
  logic            halted_q, halted_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   dsc_q, dsc_d;
  logic [TW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CNTW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [31:0] tag_pc_q  [MAX_OUTST];
  logic        tag_dsc_q [MAX_OUTST];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  logic [3:0]  fifo_exc_q  [DEPTH];

  logic          flush_any;
  logic [31:0]   flush_pc;
  logic [3:0]    exc_vec;
  logic [SW-1:0] occupancy;
  logic          credit, build, exc_push, accept, ret, drop;
  logic          data_push, fifo_push, pop;
  logic [31:0]   wr_pc, wr_inst;
  logic [3:0]    wr_exc;

  assign flush_any = flush | id_flush;
  assign flush_pc  = flush ? flush_target : id_flush_target;
  assign exc_vec   = {fetch_pc_q[1:0] != 2'b00, except_tlbr, except_pif, except_ppi};
  assign occupancy = SW'(fifo_cnt_q) + SW'(outst_q) + SW'(req_q);
  // Every slot that could end up in the FIFO is reserved before a request is built.
  assign credit    = !halted_q && !req_q && (occupancy < SW'(DEPTH)) && (outst_q < OW'(MAX_OUTST));
  assign build     = credit && (exc_vec == 4'b0000) && !flush_any;
  assign exc_push  = credit && (exc_vec != 4'b0000) && (outst_q == '0) && !flush_any;
  assign accept    = req_q && inst_sram_addr_ok;
  assign ret       = inst_sram_data_ok;
  assign drop      = tag_dsc_q[tag_rd_q] || (dsc_q != '0) || flush_any;
  assign data_push = ret && !drop;
  assign fifo_push = data_push || exc_push;
  assign pop       = (fifo_cnt_q != '0) && id_allowin && !flush_any;

  assign wr_pc   = exc_push ? fetch_pc_q : tag_pc_q[tag_rd_q];
  assign wr_inst = exc_push ? 32'h0 : inst_sram_rdata;
  assign wr_exc  = exc_push ? exc_vec : 4'b0000;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_d         = req_q;
    req_discard_d = req_discard_q;
    halted_d      = halted_q;
    addr_d        = addr_q;
    req_pc_d      = req_pc_q;
    outst_d       = outst_q + OW'(accept) - OW'(ret);
    dsc_d         = dsc_q;
    tag_wr_d      = accept ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d      = ret ? tag_inc(tag_rd_q) : tag_rd_q;
    fifo_wr_d     = fifo_push ? fifo_wr_q + PW'(1) : fifo_wr_q;
    fifo_rd_d     = pop ? fifo_rd_q + PW'(1) : fifo_rd_q;
    fifo_cnt_d    = fifo_cnt_q + CNTW'(fifo_push) - CNTW'(pop);

    if (build) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_d      = 1'b1;
      addr_d     = pc_trans;
      req_pc_d   = fetch_pc_q;
    end
    if (accept) begin
      req_d         = 1'b0;
      req_discard_d = 1'b0;
    end
    if (exc_push) halted_d = 1'b1;
    if (ret && (dsc_q != '0)) dsc_d = dsc_q - OW'(1);

    // A held request cannot be withdrawn, so its data is marked for dropping instead.
    if (flush_any) begin
      fetch_pc_d = flush_pc;
      halted_d   = 1'b0;
      dsc_d      = outst_d;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      if (req_q && !accept) req_discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= PC_INIT;
      req_q         <= 1'b0;
      req_discard_q <= 1'b0;
      halted_q      <= 1'b0;
      outst_q       <= '0;
      dsc_q         <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_q         <= req_d;
      req_discard_q <= req_discard_d;
      halted_q      <= halted_d;
      outst_q       <= outst_d;
      dsc_q         <= dsc_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Payload storage carries no reset; control qualifies every read.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    req_pc_q <= req_pc_d;
    if (accept) begin
      tag_pc_q[tag_wr_q]  <= req_pc_q;
      tag_dsc_q[tag_wr_q] <= req_discard_q;
    end
    if (fifo_push) begin
      fifo_pc_q[fifo_wr_q]   <= wr_pc;
      fifo_inst_q[fifo_wr_q] <= wr_inst;
      fifo_exc_q[fifo_wr_q]  <= wr_exc;
    end
  end

  assign fetch_pc       = fetch_pc_q;
  assign inst_sram_req  = req_q;
  assign inst_sram_addr = addr_q;
  assign if_valid       = (fifo_cnt_q != '0);
  assign if_pc          = fifo_pc_q[fifo_rd_q];
  assign if_inst        = fifo_inst_q[fifo_rd_q];
  assign if_except      = fifo_exc_q[fifo_rd_q];

endmodule
